muu_value_write_burster: RTL and testbench

Downstream neighbour of the value-set stage. It consumes that stage's write-command stream (40-bit: word address plus length in 512-bit words) and the matching value-data stream, and turns them into AXI-style memory write bursts. Bursts are capped at a maximum beat count and never cross an address boundary. The block also tracks outstanding write responses against a limit and back-pressures the value path until each burst's address has been accepted.

---
 rtl/muu_value_write_burster.sv | 139 +++++++++++++
 tb/tb_muu_value_write_burster.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muu_value_write_burster.sv
// Splits (word address, length) write commands into AXI-style write bursts capped at
// MAX_BURST beats that never cross a BOUNDARY_WORDS boundary; tracks outstanding B responses.
module muu_value_write_burster #(
   parameter int MEMORY_WIDTH    = 512,
   parameter int ADDR_WIDTH      = 33,
   parameter int MAX_BURST       = 16,
   parameter int BOUNDARY_WORDS  = 64,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [39:0]             wrcmd_data,
   input  logic                    wrcmd_valid,
   output logic                    wrcmd_ready,
   input  logic [MEMORY_WIDTH-1:0] wr_data,
   input  logic                    wr_valid,
   output logic                    wr_ready,
   output logic [ADDR_WIDTH-1:0]   mem_awaddr,
   output logic [7:0]              mem_awlen,
   output logic                    mem_awvalid,
   input  logic                    mem_awready,
   output logic [MEMORY_WIDTH-1:0] mem_wdata,
   output logic                    mem_wlast,
   output logic                    mem_wvalid,
   input  logic                    mem_wready,
   input  logic                    mem_bvalid,
   output logic                    mem_bready,
   output logic                    busy
);

   localparam int OUT_W      = $clog2(MAX_OUTSTANDING + 1);
   localparam int WORD_SHIFT = $clog2(MEMORY_WIDTH / 8);
   localparam logic [OUT_W-1:0] OUT_LIMIT  = OUT_W'(MAX_OUTSTANDING);
   localparam logic [31:0]      BOUND_MASK = 32'(BOUNDARY_WORDS - 1);

   typedef enum logic [1:0] {IDLE, ISSUE_AW, DATA} state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [7:0]       remaining_q, remaining_d;
   logic [8:0]       beats_q, beats_d;
   logic [OUT_W-1:0] outstanding_q, outstanding_d;

   logic [32:0]           room;
   logic [8:0]            burst;
   logic [31+WORD_SHIFT:0] byte_addr;
   logic in_issue, in_data;
   logic cmd_hs, aw_hs, w_hs, b_dec;

   // Burst length depends only on registered addr/remaining, so it stays stable while AW waits.
   always_comb begin
      room  = 33'(BOUNDARY_WORDS) - {1'b0, addr_q & BOUND_MASK};
      burst = {1'b0, remaining_q};
      if (burst > 9'(MAX_BURST)) burst = 9'(MAX_BURST);
      if ({24'b0, burst} > room) burst = room[8:0];
   end

   assign byte_addr = {addr_q, {WORD_SHIFT{1'b0}}};
   assign in_issue  = !rst && (state_q == ISSUE_AW);
   assign in_data   = !rst && (state_q == DATA);

   assign wrcmd_ready = !rst && (state_q == IDLE);
   assign mem_bready  = !rst;
   assign mem_awvalid = in_issue && (outstanding_q < OUT_LIMIT);
   assign mem_awaddr  = in_issue ? ADDR_WIDTH'(byte_addr) : '0;
   assign mem_awlen   = in_issue ? 8'(burst - 9'd1) : '0;
   assign mem_wdata   = wr_data;
   assign mem_wvalid  = in_data && wr_valid;
   assign wr_ready    = in_data && mem_wready;
   assign mem_wlast   = in_data && (beats_q == 9'd1);
   assign busy        = !rst && ((state_q != IDLE) || (outstanding_q != '0));

   assign cmd_hs = wrcmd_valid && wrcmd_ready;
   assign aw_hs  = mem_awvalid && mem_awready;
   assign w_hs   = mem_wvalid && mem_wready;
   // A response with nothing outstanding is a stray and must not underflow the count.
   assign b_dec  = mem_bvalid && mem_bready && (outstanding_q != '0);

   always_comb begin
      // NOTE: every variable gets a default before the case so no path can infer a latch.
      state_d     = state_q;
      addr_d      = addr_q;
      remaining_d = remaining_q;
      beats_d     = beats_q;
      case (state_q)
         IDLE: begin
            if (cmd_hs) begin
               addr_d      = wrcmd_data[31:0];
               remaining_d = wrcmd_data[39:32];
               if (wrcmd_data[39:32] != 8'd0) state_d = ISSUE_AW;
            end
         end
         ISSUE_AW: begin
            if (aw_hs) begin
               beats_d = burst;
               state_d = DATA;
            end
         end
         DATA: begin
            if (w_hs) begin
               beats_d = beats_q - 9'd1;
               if (beats_q == 9'd1) begin
                  addr_d      = addr_q + {23'b0, burst};
                  remaining_d = remaining_q - burst[7:0];
                  state_d     = (remaining_q == burst[7:0]) ? IDLE : ISSUE_AW;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      outstanding_d = outstanding_q;
      case ({aw_hs, b_dec})
         2'b10:   outstanding_d = outstanding_q + 1'b1;
         2'b01:   outstanding_d = outstanding_q - 1'b1;
         default: outstanding_d = outstanding_q;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         remaining_q   <= '0;
         beats_q       <= '0;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         remaining_q   <= remaining_d;
         beats_q       <= beats_d;
         outstanding_q <= outstanding_d;
      end
   end

endmodule

// File: tb/tb_muu_value_write_burster.sv
// Bench for muu_value_write_burster: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a burst-splitting reference model.
module tb_muu_value_write_burster;

   localparam int MW   = 512;
   localparam int AW   = 33;
   localparam int MAXB = 16;
   localparam int BW   = 64;
   localparam int MAXO = 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    len;
   } aw_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [39:0]   wrcmd_data;
   logic          wrcmd_valid, wrcmd_ready;
   logic [MW-1:0] wr_data;
   logic          wr_valid, wr_ready;
   logic [AW-1:0] mem_awaddr;
   logic [7:0]    mem_awlen;
   logic          mem_awvalid, mem_awready;
   logic [MW-1:0] mem_wdata;
   logic          mem_wlast, mem_wvalid, mem_wready;
   logic          mem_bvalid, mem_bready, busy;

   muu_value_write_burster #(
      .MEMORY_WIDTH(MW), .ADDR_WIDTH(AW), .MAX_BURST(MAXB),
      .BOUNDARY_WORDS(BW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst(rst),
      .wrcmd_data(wrcmd_data), .wrcmd_valid(wrcmd_valid), .wrcmd_ready(wrcmd_ready),
      .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
      .mem_awaddr(mem_awaddr), .mem_awlen(mem_awlen), .mem_awvalid(mem_awvalid),
      .mem_awready(mem_awready), .mem_wdata(mem_wdata), .mem_wlast(mem_wlast),
      .mem_wvalid(mem_wvalid), .mem_wready(mem_wready), .mem_bvalid(mem_bvalid),
      .mem_bready(mem_bready), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic chk1(input string name, input bit act, input bit exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0b expected %0b (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic chkv(input string name, input logic [MW-1:0] act, input logic [MW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: pending bursts, words left overall, beats left in the open burst.
   aw_t exp_aw[$];
   int  pending = 0;
   int  avail   = 0;
   int  outs    = 0;

   aw_t aw_log[$];
   int  wlast_log[$];
   int  w_count = 0;
   bit  acc_q   = 1'b0;
   bit  rnd_mode = 1'b0;

   function automatic void split(input logic [31:0] a0, input int len);
      logic [31:0] a;
      logic [37:0] full;
      int left, room, b;
      aw_t e;
      a = a0;
      left = len;
      while (left > 0) begin
         room = BW - int'(a % BW);
         b = left;
         if (b > MAXB) b = MAXB;
         if (b > room) b = room;
         full = {a, 6'b0};
         e.addr = full[AW-1:0];
         e.len  = 8'(b - 1);
         exp_aw.push_back(e);
         a = a + 32'(b);
         left -= b;
      end
   endfunction

   always @(negedge clk) begin : monitor
      bit in_data, in_issue, exp_awv, aw_hs, w_hs, b_dec, cmd_hs;
      if (rst) begin
         chk1("rst_wrcmd_ready", wrcmd_ready, 1'b0);
         chk1("rst_wr_ready", wr_ready, 1'b0);
         chk1("rst_awvalid", mem_awvalid, 1'b0);
         chk1("rst_wvalid", mem_wvalid, 1'b0);
         chk1("rst_wlast", mem_wlast, 1'b0);
         chk1("rst_bready", mem_bready, 1'b0);
         chk1("rst_busy", busy, 1'b0);
         chkv("rst_awaddr", MW'(mem_awaddr), '0);
         chkv("rst_awlen", MW'(mem_awlen), '0);
         exp_aw.delete();
         pending = 0;
         avail   = 0;
         outs    = 0;
         acc_q   = 1'b0;
      end else begin
         in_data  = (avail > 0);
         in_issue = !in_data && (exp_aw.size() > 0);
         exp_awv  = in_issue && (outs < MAXO);
         chk1("wrcmd_ready", wrcmd_ready, pending == 0);
         chk1("bready", mem_bready, 1'b1);
         chk1("busy", busy, (pending > 0) || (outs > 0));
         chk1("awvalid", mem_awvalid, exp_awv);
         chk1("wr_ready", wr_ready, in_data && mem_wready);
         chk1("wvalid", mem_wvalid, in_data && wr_valid);
         chk1("wlast", mem_wlast, avail == 1);
         if (exp_awv) begin
            chkv("awaddr", MW'(mem_awaddr), MW'(exp_aw[0].addr));
            chkv("awlen", MW'(mem_awlen), MW'(exp_aw[0].len));
         end
         if (in_data) chkv("wdata", mem_wdata, wr_data);

         if (mem_awvalid && mem_awready) aw_log.push_back('{addr: mem_awaddr, len: mem_awlen});
         if (mem_wvalid && mem_wready) begin
            w_count++;
            if (mem_wlast) wlast_log.push_back(w_count);
         end
         acc_q = wr_valid && wr_ready;

         cmd_hs = wrcmd_valid && (pending == 0);
         aw_hs  = exp_awv && mem_awready;
         w_hs   = in_data && wr_valid && mem_wready;
         b_dec  = mem_bvalid && (outs > 0);
         if (aw_hs) begin
            avail = int'(exp_aw[0].len) + 1;
            void'(exp_aw.pop_front());
         end
         if (w_hs) begin
            avail--;
            pending--;
         end
         outs = outs + (aw_hs ? 1 : 0) - (b_dec ? 1 : 0);
         if (cmd_hs) begin
            split(wrcmd_data[31:0], int'(wrcmd_data[39:32]));
            pending += int'(wrcmd_data[39:32]);
         end
      end
   end

   function automatic logic [MW-1:0] rand_beat();
      logic [MW-1:0] v;
      for (int i = 0; i < MW / 32; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
      if (acc_q) wr_data = rand_beat();
      if (rnd_mode) begin
         mem_awready = ($urandom_range(0, 3) != 0);
         mem_wready  = ($urandom_range(0, 3) != 0);
         mem_bvalid  = ($urandom_range(0, 1) == 1);
         wr_valid    = ($urandom_range(0, 3) != 0);
      end
   endtask

   // Called just after a clock edge; returns the number of cycles spent waiting for ready.
   task automatic send_cmd(input logic [31:0] a, input logic [7:0] len, output int waited);
      wrcmd_data  = {len, a};
      wrcmd_valid = 1'b1;
      waited = 0;
      @(negedge clk);
      while (!wrcmd_ready && waited < 3000) begin
         tick();
         waited++;
         @(negedge clk);
      end
      chk1("cmd_accept_timeout", wrcmd_ready, 1'b1);
      tick();
      wrcmd_valid = 1'b0;
   endtask

   task automatic wait_done();
      int n = 0;
      @(negedge clk);
      while (!wrcmd_ready && n < 3000) begin
         tick();
         n++;
         @(negedge clk);
      end
      chk1("done_timeout", wrcmd_ready, 1'b1);
      tick();
   endtask

   task automatic check_aw(input int idx, input logic [AW-1:0] addr, input logic [7:0] len);
      if (aw_log.size() > idx) begin
         chkv("lit_awaddr", MW'(aw_log[idx].addr), MW'(addr));
         chkv("lit_awlen", MW'(aw_log[idx].len), MW'(len));
      end else begin
         chkv("lit_aw_count", MW'(aw_log.size()), MW'(idx + 1));
      end
   endtask

   task automatic check_wlast(input int idx, input int w_base, input int beat);
      if (wlast_log.size() > idx) chkv("lit_wlast_pos", MW'(wlast_log[idx] - w_base), MW'(beat));
      else chkv("lit_wlast_count", MW'(wlast_log.size()), MW'(idx + 1));
   endtask

   initial begin : main
      int ab, lb, wb, w;
      bit pat[4];
      logic [31:0] r, a;
      logic [7:0]  len;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      wrcmd_valid = 1'b0; wrcmd_data = '0; wr_valid = 1'b0; wr_data = rand_beat();
      mem_awready = 1'b0; mem_wready = 1'b0; mem_bvalid = 1'b0;
      rst = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      @(negedge clk);
      chk1("ready_after_reset", wrcmd_ready, 1'b1);
      tick();
      mem_awready = 1'b1; mem_wready = 1'b1; wr_valid = 1'b1; mem_bvalid = 1'b1;

      // Single burst
      ab = aw_log.size(); lb = wlast_log.size(); wb = w_count;
      send_cmd(32'h10, 8'd4, w);
      wait_done();
      chkv("single_aw_count", MW'(aw_log.size() - ab), MW'(1));
      check_aw(ab, 33'h400, 8'd3);
      chkv("single_beats", MW'(w_count - wb), MW'(4));
      check_wlast(lb, wb, 4);

      // Boundary split
      ab = aw_log.size(); lb = wlast_log.size(); wb = w_count;
      send_cmd(32'd60, 8'd10, w);
      wait_done();
      check_aw(ab, 33'hF00, 8'd3);
      check_aw(ab + 1, 33'h1000, 8'd5);
      check_wlast(lb, wb, 4);
      check_wlast(lb + 1, wb, 10);

      // Max-burst split
      ab = aw_log.size(); wb = w_count;
      send_cmd(32'd0, 8'd40, w);
      wait_done();
      check_aw(ab, 33'h0, 8'd15);
      check_aw(ab + 1, 33'h400, 8'd15);
      check_aw(ab + 2, 33'h800, 8'd7);
      chkv("maxb_beats", MW'(w_count - wb), MW'(40));

      // Zero length, followed immediately by another command
      ab = aw_log.size(); wb = w_count;
      send_cmd(32'h123, 8'd0, w);
      send_cmd(32'h20, 8'd1, w);
      chkv("zero_next_wait", MW'(w), MW'(0));
      wait_done();
      chkv("zero_aw_count", MW'(aw_log.size() - ab), MW'(1));
      check_aw(ab, 33'h800, 8'd0);

      // Outstanding limit
      repeat (20) tick();
      mem_bvalid = 1'b0;
      ab = aw_log.size();
      for (int i = 0; i < 9; i++) send_cmd(32'h200 + 32'(i), 8'd1, w);
      repeat (3) tick();
      @(negedge clk);
      chk1("limit_aw_held", mem_awvalid, 1'b0);
      chkv("limit_aw_count", MW'(aw_log.size() - ab), MW'(8));
      tick();
      mem_bvalid = 1'b1;
      tick();
      @(negedge clk);
      chk1("limit_aw_after_b", mem_awvalid, 1'b1);
      chk1("limit_busy_aw_b", busy, 1'b1);
      tick();
      mem_bvalid = 1'b0;
      wait_done();
      send_cmd(32'h300, 8'd1, w);
      send_cmd(32'h301, 8'd1, w);
      repeat (3) tick();
      @(negedge clk);
      chk1("limit_aw_held2", mem_awvalid, 1'b0);
      chkv("limit_aw_count2", MW'(aw_log.size() - ab), MW'(10));
      tick();
      mem_bvalid = 1'b1;
      repeat (20) tick();
      wait_done();

      // Stall pattern on mem_wready
      lb = wlast_log.size(); wb = w_count;
      send_cmd(32'h40, 8'd4, w);
      for (int i = 0; i < 12; i++) begin
         mem_wready = pat[i % 4];
         tick();
      end
      mem_wready = 1'b1;
      wait_done();
      chkv("stall_beats", MW'(w_count - wb), MW'(4));
      check_wlast(lb, wb, 4);

      // Reset mid-burst with responses outstanding
      mem_bvalid = 1'b0;
      send_cmd(32'h0, 8'd40, w);
      repeat (5) tick();
      rst = 1'b1;
      @(negedge clk);
      chk1("midrst_awvalid", mem_awvalid, 1'b0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk1("midrst_busy", busy, 1'b0);
      chk1("midrst_ready", wrcmd_ready, 1'b1);
      tick();
      mem_bvalid = 1'b1;

      // Randomized traffic
      rnd_mode = 1'b1;
      for (int n = 0; n < 150; n++) begin
         repeat ($urandom_range(0, 3)) tick();
         r = $urandom();
         case ($urandom_range(0, 2))
            0:       a = r;
            1:       a = 32'hFFFF_FFC0 | (r & 32'd63);
            default: a = (r & ~32'd63) | (32'd60 + (r & 32'd3));
         endcase
         len = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 40));
         send_cmd(a, len, w);
      end
      rnd_mode = 1'b0;
      mem_awready = 1'b1; mem_wready = 1'b1; wr_valid = 1'b1; mem_bvalid = 1'b1;
      wait_done();
      repeat (20) tick();
      @(negedge clk);
      chk1("final_idle", busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
